// File: rtl/ethernet_frame_tx_if.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : ethernet_frame_tx_if
//  Description : Frame request, payload stream and line-side bundle for
//                ethernet_frame_tx.
//  Revision    : 1.0  initial release
// ============================================================================
interface ethernet_frame_tx_if;
    logic        start;
    logic [47:0] dest_mac;
    logic [47:0] src_mac;
    logic [15:0] eth_type;
    logic [7:0]  pl_data;
    logic        pl_valid;
    logic        pl_last;
    logic        pl_ready;
    logic [7:0]  tx_data;
    logic        tx_valid;
    logic        busy;
    logic        done;
    logic        tx_err;

    modport master (
        output start, dest_mac, src_mac, eth_type, pl_data, pl_valid, pl_last,
        input  pl_ready, tx_data, tx_valid, busy, done, tx_err
    );

    modport slave (
        input  start, dest_mac, src_mac, eth_type, pl_data, pl_valid, pl_last,
        output pl_ready, tx_data, tx_valid, busy, done, tx_err
    );
endinterface
`default_nettype wire

// File: rtl/ethernet_frame_tx.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : ethernet_frame_tx
//  Description : Byte-wide Ethernet frame transmitter: preamble, SFD, header,
//                streamed payload, optional zero padding (ETH_TX_PAD_EN),
//                CRC-32 FCS and inter-frame gap.
//  Revision    : 1.0  initial release
// ============================================================================
module ethernet_frame_tx #(
    parameter int IFG_BYTES   = 12,
    parameter int MIN_PAYLOAD = 46
) (
    input  wire                clk,
    input  wire                reset,
    ethernet_frame_tx_if.slave bus
);

    localparam logic [7:0]  c_PREAMBLE_BYTE = 8'h55;
    localparam logic [7:0]  c_SFD_BYTE      = 8'hD5;
    localparam logic [10:0] c_MAX_PAYLOAD   = 11'd1500;
    localparam logic [15:0] c_IFG_LAST      = 16'(IFG_BYTES - 1);
    localparam logic [31:0] c_CRC_INIT      = 32'hFFFF_FFFF;

    typedef enum logic [3:0] {
        IDLE     = 4'd0,
        PREAMBLE = 4'd1,
        SFD      = 4'd2,
        DEST     = 4'd3,
        SRC      = 4'd4,
        TYPE     = 4'd5,
        PAYLOAD  = 4'd6,
        PAD      = 4'd7,
        FCS      = 4'd8,
        IFG      = 4'd9
    } state_t;

    state_t        r_state;
    state_t        w_state_nxt;
    logic [15:0]   r_cnt;
    logic [10:0]   r_pl_cnt;
    logic [31:0]   r_crc;
    logic [111:0]  r_hdr;
    logic          r_done;
    logic          r_err;

    logic [7:0]    w_tx_data;
    logic          w_tx_valid;
    logic          w_abort;
    logic          w_done_set;
    logic          w_crc_en;
    logic          w_pl_inc;
    logic [31:0]   w_fcs;

    function automatic logic [31:0] f_crc_byte(input logic [31:0] crc, input logic [7:0] data);
        logic [31:0] c;
        c = crc ^ {24'd0, data};
        for (int i = 0; i < 8; i++) begin
            c = c[0] ? ((c >> 1) ^ 32'hEDB8_8320) : (c >> 1);
        end
        return c;
    endfunction

    assign w_fcs = ~r_crc;

    always_comb begin
        w_state_nxt = r_state;
        w_tx_data   = 8'h00;
        w_tx_valid  = 1'b0;
        w_abort     = 1'b0;
        w_done_set  = 1'b0;
        w_crc_en    = 1'b0;
        w_pl_inc    = 1'b0;
        case (r_state)
            IDLE: begin
                if (bus.start) w_state_nxt = PREAMBLE;
            end
            PREAMBLE: begin
                w_tx_valid = 1'b1;
                w_tx_data  = c_PREAMBLE_BYTE;
                if (r_cnt == 16'd6) w_state_nxt = SFD;
            end
            SFD: begin
                w_tx_valid  = 1'b1;
                w_tx_data   = c_SFD_BYTE;
                w_state_nxt = DEST;
            end
            DEST, SRC, TYPE: begin
                w_tx_valid = 1'b1;
                w_tx_data  = r_hdr[111:104];
                w_crc_en   = 1'b1;
                if (r_state == DEST && r_cnt == 16'd5) w_state_nxt = SRC;
                if (r_state == SRC  && r_cnt == 16'd5) w_state_nxt = TYPE;
                if (r_state == TYPE && r_cnt == 16'd1) w_state_nxt = PAYLOAD;
            end
            PAYLOAD: begin
                // tx_valid stays up through the underrun cycle; the drop is seen next cycle
                w_tx_valid = 1'b1;
                w_tx_data  = bus.pl_data;
                if (!bus.pl_valid) begin
                    w_abort     = 1'b1;
                    w_state_nxt = IFG;
                end else begin
                    w_crc_en = 1'b1;
                    w_pl_inc = 1'b1;
                    if (bus.pl_last) begin
`ifdef ETH_TX_PAD_EN
                        w_state_nxt = ((r_pl_cnt + 11'd1) < 11'(MIN_PAYLOAD)) ? PAD : FCS;
`else
                        w_state_nxt = FCS;
`endif
                    end else if (r_pl_cnt == c_MAX_PAYLOAD - 11'd1) begin
                        w_abort     = 1'b1;
                        w_state_nxt = IFG;
                    end
                end
            end
`ifdef ETH_TX_PAD_EN
            PAD: begin
                w_tx_valid = 1'b1;
                w_crc_en   = 1'b1;
                w_pl_inc   = 1'b1;
                if (r_pl_cnt >= 11'(MIN_PAYLOAD) - 11'd1) w_state_nxt = FCS;
            end
`endif
            FCS: begin
                w_tx_valid = 1'b1;
                case (r_cnt[1:0])
                    2'd0:    w_tx_data = w_fcs[7:0];
                    2'd1:    w_tx_data = w_fcs[15:8];
                    2'd2:    w_tx_data = w_fcs[23:16];
                    default: w_tx_data = w_fcs[31:24];
                endcase
                if (r_cnt == 16'd3) begin
                    w_done_set  = 1'b1;
                    w_state_nxt = IFG;
                end
            end
            IFG: begin
                if (r_cnt >= c_IFG_LAST) w_state_nxt = IDLE;
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state  <= IDLE;
            r_cnt    <= 16'd0;
            r_pl_cnt <= 11'd0;
            r_crc    <= c_CRC_INIT;
            r_hdr    <= '0;
            r_done   <= 1'b0;
            r_err    <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= (w_state_nxt != r_state || r_state == IDLE) ? 16'd0 : r_cnt + 16'd1;
            r_done  <= w_done_set;
            r_err   <= w_abort;
            if (r_state == IDLE) begin
                r_pl_cnt <= 11'd0;
                r_crc    <= c_CRC_INIT;
                if (bus.start) r_hdr <= {bus.dest_mac, bus.src_mac, bus.eth_type};
            end else begin
                if (w_crc_en) r_crc <= f_crc_byte(r_crc, w_tx_data);
                if (w_pl_inc) r_pl_cnt <= r_pl_cnt + 11'd1;
                // header goes out MSB first by shifting the latched copy
                if (r_state == DEST || r_state == SRC || r_state == TYPE)
                    r_hdr <= {r_hdr[103:0], 8'h00};
            end
        end
    end

    assign bus.tx_data  = w_tx_data;
    assign bus.tx_valid = w_tx_valid;
    assign bus.pl_ready = (r_state == PAYLOAD);
    assign bus.busy     = (r_state != IDLE);
    assign bus.done     = r_done;
    assign bus.tx_err   = r_err;

endmodule
`default_nettype wire

// File: tb/tb_ethernet_frame_tx.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : tb_ethernet_frame_tx
//  Description : Directed self-checking bench for ethernet_frame_tx.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_ethernet_frame_tx;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    ethernet_frame_tx_if bus();

    ethernet_frame_tx #(.IFG_BYTES(12), .MIN_PAYLOAD(46)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    typedef struct {
        logic [47:0] dest;
        logic [47:0] src;
        logic [15:0] typ;
        int          len;
        logic [7:0]  seed;
        logic [7:0]  step;
        int          exp_total;
    } vec_t;

    vec_t       vecs [5];
    logic [7:0] pl_mem [0:1599];
    int         n_cmp = 0;
    int         n_bad = 0;

    // line monitor, sampled mid-way between the driving edge and the active edge
    logic [7:0] cap [$];
    int ncyc = 0, first_v = 0, last_v = 0, done_cnt = 0, err_cnt = 0, err_at = 0, idle_bad = 0;

    always begin
        @(negedge clk);
        #2;
        ncyc++;
        if (bus.tx_valid) begin
            if (cap.size() == 0) first_v = ncyc;
            last_v = ncyc;
            cap.push_back(bus.tx_data);
        end else if (bus.tx_data != 8'h00) begin
            idle_bad++;
        end
        if (bus.done) done_cnt++;
        if (bus.tx_err) begin
            err_cnt++;
            err_at = ncyc;
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] crc_bitwise(input logic [31:0] c_in, input logic [7:0] b);
        logic [31:0] c;
        c = c_in;
        for (int i = 0; i < 8; i++) begin
            if (c[0] ^ b[i]) c = (c >> 1) ^ 32'hEDB8_8320;
            else             c = c >> 1;
        end
        return c;
    endfunction

    task automatic fill(input logic [7:0] seed, input logic [7:0] step, input int len);
        logic [7:0] v;
        v = seed;
        for (int i = 0; i < len; i++) begin
            pl_mem[i] = v;
            v = v + step;
        end
    endtask

    task automatic mon_clear();
        cap.delete();
        done_cnt = 0;
        err_cnt  = 0;
        first_v  = 0;
        last_v   = 0;
        err_at   = 0;
    endtask

    task automatic run_frame(input vec_t v, input int underrun_at);
        int idx;
        int cyc;
        @(negedge clk);
        bus.dest_mac = v.dest;
        bus.src_mac  = v.src;
        bus.eth_type = v.typ;
        bus.start    = 1'b1;
        bus.pl_valid = 1'b1;
        bus.pl_data  = pl_mem[0];
        bus.pl_last  = (v.len == 1);
        @(negedge clk);
        bus.start = 1'b0;
        #1;
        check("start_latency", {23'd0, bus.tx_valid, bus.tx_data}, 32'h155);
        idx = 0;
        cyc = 0;
        while (idx < v.len && err_cnt == 0 && cyc < 4000) begin
            bus.pl_data = pl_mem[idx];
            bus.pl_last = (idx == v.len - 1);
            if (bus.pl_ready) begin
                if (idx == underrun_at) bus.pl_valid = 1'b0;
                else idx++;
            end
            @(negedge clk);
            cyc++;
        end
        bus.pl_valid = 1'b0;
        bus.pl_last  = 1'b0;
        cyc = 0;
        while (done_cnt == 0 && err_cnt == 0 && cyc < 200) begin
            @(negedge clk);
            cyc++;
        end
        check("frame_end_seen", {31'd0, (done_cnt + err_cnt) > 0}, 32'd1);
    endtask

    task automatic wait_idle();
        int cyc;
        cyc = 0;
        while (bus.busy && cyc < 100) begin
            @(negedge clk);
            cyc++;
        end
        check("idle_reached", {31'd0, bus.busy}, 32'd0);
    endtask

    task automatic check_vec(input vec_t v, input string tag);
        logic [7:0]  exp_q [$];
        logic [31:0] crc;
        int          first_diff;
        int          nmin;
        fill(v.seed, v.step, v.len);
        mon_clear();
        run_frame(v, -1);
        wait_idle();
        for (int i = 0; i < 7; i++) exp_q.push_back(8'h55);
        exp_q.push_back(8'hD5);
        for (int i = 5; i >= 0; i--) exp_q.push_back(v.dest[8*i +: 8]);
        for (int i = 5; i >= 0; i--) exp_q.push_back(v.src[8*i +: 8]);
        exp_q.push_back(v.typ[15:8]);
        exp_q.push_back(v.typ[7:0]);
        for (int i = 0; i < v.len; i++) exp_q.push_back(pl_mem[i]);
`ifdef ETH_TX_PAD_EN
        for (int i = v.len; i < 46; i++) exp_q.push_back(8'h00);
`endif
        crc = 32'hFFFF_FFFF;
        for (int i = 8; i < exp_q.size(); i++) crc = crc_bitwise(crc, exp_q[i]);
        crc = ~crc;
        for (int i = 0; i < 4; i++) exp_q.push_back(crc[8*i +: 8]);

        check($sformatf("%s_len", tag), cap.size(), v.exp_total);
        check($sformatf("%s_contiguous", tag), last_v - first_v + 1, cap.size());
        first_diff = -1;
        nmin = (cap.size() < exp_q.size()) ? cap.size() : exp_q.size();
        for (int i = 0; i < nmin; i++) begin
            if (first_diff < 0 && cap[i] !== exp_q[i]) first_diff = i;
        end
        if (first_diff < 0 && cap.size() != exp_q.size()) first_diff = nmin;
        check($sformatf("%s_first_bad_byte_index", tag), first_diff, 32'hFFFF_FFFF);
        crc = 32'hFFFF_FFFF;
        for (int i = 8; i < cap.size(); i++) crc = crc_bitwise(crc, cap[i]);
        check($sformatf("%s_crc_residue", tag), crc, 32'hDEBB_20E3);
        check($sformatf("%s_done_pulses", tag), done_cnt, 32'd1);
        check($sformatf("%s_err_pulses", tag), err_cnt, 32'd0);
    endtask

    initial begin
        int   cyc;
        int   t_mark;
        int   n0;
        vec_t vo;

        reset        = 1'b1;
        bus.start    = 1'b0;
        bus.dest_mac = '0;
        bus.src_mac  = '0;
        bus.eth_type = '0;
        bus.pl_data  = '0;
        bus.pl_valid = 1'b0;
        bus.pl_last  = 1'b0;

`ifdef ETH_TX_PAD_EN
        vecs[0] = '{48'hFFFF_FFFF_FFFF, 48'h0011_2233_4455, 16'h0800, 46,   8'h00, 8'h01, 72};
        vecs[1] = '{48'hFFFF_FFFF_FFFF, 48'h0011_2233_4455, 16'h0800, 1,    8'hAB, 8'h00, 72};
        vecs[2] = '{48'h0A1B_2C3D_4E5F, 48'h6655_4433_2211, 16'h86DD, 60,   8'h10, 8'h03, 86};
        vecs[3] = '{48'hFFFF_FFFF_FFFF, 48'h0011_2233_4455, 16'h0800, 45,   8'hF0, 8'h01, 72};
        vecs[4] = '{48'h0200_0000_0001, 48'h0011_2233_4455, 16'h0800, 1500, 8'h00, 8'h07, 1526};
`else
        vecs[0] = '{48'hFFFF_FFFF_FFFF, 48'h0011_2233_4455, 16'h0800, 46,   8'h00, 8'h01, 72};
        vecs[1] = '{48'hFFFF_FFFF_FFFF, 48'h0011_2233_4455, 16'h0800, 1,    8'hAB, 8'h00, 27};
        vecs[2] = '{48'h0A1B_2C3D_4E5F, 48'h6655_4433_2211, 16'h86DD, 60,   8'h10, 8'h03, 86};
        vecs[3] = '{48'hFFFF_FFFF_FFFF, 48'h0011_2233_4455, 16'h0800, 45,   8'hF0, 8'h01, 71};
        vecs[4] = '{48'h0200_0000_0001, 48'h0011_2233_4455, 16'h0800, 1500, 8'h00, 8'h07, 1526};
`endif

        repeat (3) @(negedge clk);
        #2;
        check("rst_tx_valid", {31'd0, bus.tx_valid}, 32'd0);
        check("rst_tx_data",  {24'd0, bus.tx_data},  32'd0);
        check("rst_pl_ready", {31'd0, bus.pl_ready}, 32'd0);
        check("rst_busy",     {31'd0, bus.busy},     32'd0);
        check("rst_done",     {31'd0, bus.done},     32'd0);
        check("rst_tx_err",   {31'd0, bus.tx_err},   32'd0);
        @(negedge clk);
        reset = 1'b0;

        for (int i = 0; i < 5; i++) check_vec(vecs[i], $sformatf("v%0d", i));

        // underrun at payload byte 10, then a start held through the gap
        fill(8'h00, 8'h01, 46);
        mon_clear();
        run_frame(vecs[0], 10);
        @(negedge clk);
        check("underrun_err_pulses", err_cnt, 32'd1);
        check("underrun_no_done", done_cnt, 32'd0);
        check("underrun_valid_drop_cycle", err_at, last_v + 1);
        check("underrun_bytes_sent", cap.size(), 32'd33);
        t_mark    = err_at;
        bus.start = 1'b1;
        mon_clear();
        cyc = 0;
        while (cap.size() == 0 && cyc < 50) begin
            @(negedge clk);
            #3;
            cyc++;
        end
        bus.start = 1'b0;
        check("abort_gap_to_preamble", first_v - t_mark, 32'd13);

        // reset while the fourth source byte is on the line
        cyc = 0;
        while (cap.size() < 18 && cyc < 50) begin
            @(negedge clk);
            #3;
            cyc++;
        end
        check("src_byte3_value", {24'd0, cap[17]}, 32'h33);
        reset = 1'b1;
        @(negedge clk);
        #2;
        check("midframe_rst_tx_valid", {31'd0, bus.tx_valid}, 32'd0);
        check("midframe_rst_busy", {31'd0, bus.busy}, 32'd0);
        reset = 1'b0;
        repeat (3) @(negedge clk);
        check("midframe_rst_no_done", done_cnt, 32'd0);
        check_vec(vecs[0], "after_reset");

        // start raised while the gap is still running
        fill(8'h00, 8'h01, 46);
        mon_clear();
        run_frame(vecs[0], -1);
        t_mark    = last_v;
        n0        = cap.size();
        bus.start = 1'b1;
        cyc = 0;
        while (cap.size() == n0 && cyc < 50) begin
            @(negedge clk);
            #3;
            cyc++;
        end
        bus.start = 1'b0;
        check("b2b_fcs_to_preamble", last_v - t_mark, 32'd14);
        wait_idle();

        // no pl_last within 1500 bytes
        vo = '{48'hFFFF_FFFF_FFFF, 48'h0011_2233_4455, 16'h0800, 1600, 8'h00, 8'h01, 0};
        fill(vo.seed, vo.step, vo.len);
        mon_clear();
        run_frame(vo, -1);
        @(negedge clk);
        check("oversize_err_pulses", err_cnt, 32'd1);
        check("oversize_no_done", done_cnt, 32'd0);
        check("oversize_bytes_sent", cap.size(), 32'd1522);
        wait_idle();

        check("idle_tx_data_zero", idle_bad, 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
